// File: rtl/avalon_cmd_sequencer_if.sv
// Command stream, read-response stream and Avalon-MM host bus of the command sequencer.
// The sequencer (Avalon host) takes the master modport; the driver/peripheral side takes slave.
interface avalon_cmd_sequencer_if #(
    parameter int ADDR_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [31:0]       cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_timeout;

    logic              av_read;
    logic              av_write;
    logic [ADDR_W-1:0] av_address;
    logic [31:0]       av_writedata;
    logic              av_read_valid;
    logic [31:0]       av_readdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
        input  rsp_ready, av_read_valid, av_readdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        output av_read, av_write, av_address, av_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_wdata,
        output rsp_ready, av_read_valid, av_readdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        input  av_read, av_write, av_address, av_writedata
    );
endinterface

// File: rtl/avalon_cmd_sequencer.sv
// Queues register-access commands in a FIFO and issues them one at a time on an Avalon-MM host bus.
// state   | meaning
// IDLE    | pop the FIFO head when one is queued
// WR      | one-cycle av_write strobe
// RD      | one-cycle av_read strobe; same-cycle read_valid is accepted
// RD_WAIT | wait for read_valid, abort after TIMEOUT cycles
// RESP    | hold the read response until rsp_ready
module avalon_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    avalon_cmd_sequencer_if.master       bus,
    output logic                         busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RESP} state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;

    logic              fifo_wr   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [31:0]       fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              push;
    logic              pop;

    assign push = bus.cmd_valid && bus.cmd_ready;
    assign pop  = (state == IDLE) && (count != '0);
    assign busy = (state != IDLE) || (count != '0);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    // cmd_ready comes from the next count, so a full FIFO shows not-ready even on a popping cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.cmd_ready <= 1'b1;
        end else begin
            if (push) begin
                fifo_wr[wr_ptr]   <= bus.cmd_write;
                fifo_addr[wr_ptr] <= bus.cmd_address;
                fifo_data[wr_ptr] <= bus.cmd_wdata;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count         <= count_nxt;
            bus.cmd_ready <= (count_nxt != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            timer            <= '0;
            bus.av_read      <= 1'b0;
            bus.av_write     <= 1'b0;
            bus.av_address   <= '0;
            bus.av_writedata <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.rsp_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.av_address <= fifo_addr[rd_ptr];
                        if (fifo_wr[rd_ptr]) begin
                            bus.av_write     <= 1'b1;
                            bus.av_writedata <= fifo_data[rd_ptr];
                            state            <= WR;
                        end else begin
                            bus.av_read <= 1'b1;
                            state       <= RD;
                        end
                    end
                end
                WR: begin
                    bus.av_write <= 1'b0;
                    state        <= IDLE;
                end
                RD: begin
                    bus.av_read <= 1'b0;
                    if (bus.av_read_valid) begin
                        bus.rsp_rdata   <= bus.av_readdata;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        timer <= '0;
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.av_read_valid) begin
                        bus.rsp_rdata   <= bus.av_readdata;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        bus.rsp_rdata   <= '0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
